// File: rtl/mem_stage_ctrl.sv
// Memory-stage access sequencer: drives a req/gnt/rvalid data port, formats
// sub-word stores/loads, and stalls the pipeline while an access is in flight.
module mem_stage_ctrl #(
    parameter int TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemReadM,
    input  logic        MemWriteM,
    input  logic [2:0]  Funct3M,
    input  logic [31:0] ALUResultM,
    input  logic [31:0] WriteDataM,
    output logic        StallM,
    output logic [31:0] ReadDataM,
    output logic        MisalignM,
    output logic        TimeoutM,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

    state_t         r_state;
    logic [CW-1:0]  r_cnt;
    logic [2:0]     r_f3;
    logic [1:0]     r_off;
    logic           r_req, r_we, r_misalign, r_timeout;
    logic [31:0]    r_addr, r_wdata, r_rdata;
    logic [3:0]     r_wstrb;

    logic           w_access, w_write, w_misalign;
    logic [3:0]     w_wstrb;
    logic [31:0]    w_wdata, w_load;
    logic [7:0]     w_byte;
    logic [15:0]    w_half;

    assign w_access = MemReadM | MemWriteM;
    assign w_write  = MemWriteM;

    always_comb begin
        w_misalign = ((Funct3M[1:0] == 2'b01) & ALUResultM[0]) |
                     ((Funct3M == 3'b010) & (ALUResultM[1:0] != 2'b00));
        w_wstrb = 4'b0000;
        w_wdata = 32'h0;
        if (w_write) begin
            case (Funct3M[1:0])
                2'b00: begin
                    w_wstrb = 4'b0001 << ALUResultM[1:0];
                    w_wdata = {4{WriteDataM[7:0]}};
                end
                2'b01: begin
                    w_wstrb = 4'b0011 << {ALUResultM[1], 1'b0};
                    w_wdata = {2{WriteDataM[15:0]}};
                end
                default: begin
                    w_wstrb = 4'b1111;
                    w_wdata = WriteDataM;
                end
            endcase
        end
    end

    // Lane select uses the offset latched at request time, not the live address.
    always_comb begin
        w_byte = mem_rdata[{r_off, 3'b000} +: 8];
        w_half = r_off[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (r_f3)
            3'b000:  w_load = {{24{w_byte[7]}}, w_byte};
            3'b100:  w_load = {24'h0, w_byte};
            3'b001:  w_load = {{16{w_half[15]}}, w_half};
            3'b101:  w_load = {16'h0, w_half};
            default: w_load = mem_rdata;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_f3       <= 3'b000;
            r_off      <= 2'b00;
            r_req      <= 1'b0;
            r_we       <= 1'b0;
            r_addr     <= 32'h0;
            r_wdata    <= 32'h0;
            r_wstrb    <= 4'b0000;
            r_rdata    <= 32'h0;
            r_misalign <= 1'b0;
            r_timeout  <= 1'b0;
        end else begin
            r_misalign <= 1'b0;
            r_timeout  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_access) begin
                        if (w_misalign) begin
                            r_state    <= S_DONE;
                            r_misalign <= 1'b1;
                        end else begin
                            r_state <= S_REQ;
                            r_cnt   <= '0;
                            r_req   <= 1'b1;
                            r_we    <= w_write;
                            r_addr  <= {ALUResultM[31:2], 2'b00};
                            r_wdata <= w_wdata;
                            r_wstrb <= w_wstrb;
                            r_f3    <= Funct3M;
                            r_off   <= ALUResultM[1:0];
                        end
                    end
                end
                S_REQ: begin
                    if (mem_gnt || r_cnt == LIMIT) begin
                        r_req   <= 1'b0;
                        r_we    <= 1'b0;
                        r_addr  <= 32'h0;
                        r_wdata <= 32'h0;
                        r_wstrb <= 4'b0000;
                    end
                    // Grant beats the limit when both land in the same cycle.
                    if (mem_gnt) begin
                        r_state <= r_we ? S_DONE : S_WAIT;
                        r_cnt   <= r_cnt + CW'(1);
                    end else if (r_cnt == LIMIT) begin
                        r_state   <= S_DONE;
                        r_timeout <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                S_WAIT: begin
                    if (mem_rvalid) begin
                        r_rdata <= w_load;
                        r_state <= S_DONE;
                    end else if (r_cnt == LIMIT) begin
                        r_state   <= S_DONE;
                        r_timeout <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Gated by reset so every output reads 0 while reset is held.
    assign StallM    = reset & (((r_state == S_IDLE) & w_access) |
                                (r_state == S_REQ) | (r_state == S_WAIT));
    assign ReadDataM = r_rdata;
    assign MisalignM = r_misalign;
    assign TimeoutM  = r_timeout;
    assign mem_req   = r_req;
    assign mem_we    = r_we;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;
    assign mem_wstrb = r_wstrb;
endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Scoreboard bench for mem_stage_ctrl: directed accesses push expected bus
// beats and completions; a monitor pops and compares as the DUT presents them.
module tb_mem_stage_ctrl;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        MemReadM = 1'b0, MemWriteM = 1'b0;
    logic [2:0]  Funct3M = 3'b000;
    logic [31:0] ALUResultM = 32'h0, WriteDataM = 32'h0;
    logic        StallM, MisalignM, TimeoutM;
    logic [31:0] ReadDataM;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_gnt = 1'b0, mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = 32'h0;

    mem_stage_ctrl #(.TIMEOUT(64)) dut (
        .clk(clk), .reset(reset), .MemReadM(MemReadM), .MemWriteM(MemWriteM),
        .Funct3M(Funct3M), .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
        .StallM(StallM), .ReadDataM(ReadDataM), .MisalignM(MisalignM), .TimeoutM(TimeoutM),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rdata;
        logic        mis;
        logic        tmo;
        int          stalls;
        bit          req;
    } cmp_t;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
        bit          chk_wd;
    } bus_t;

    cmp_t cq[$];
    bus_t bq[$];
    int checks = 0;
    int errors = 0;

    int          gnt_dly = 0, rv_dly = 0;
    logic [31:0] rsp_data = 32'h0, force_data = 32'h0;
    bit          force_rsp = 1'b0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    // Memory responder: grants after gnt_dly REQ cycles, returns read data rv_dly cycles later.
    initial begin
        int req_cycles;
        int rv_cycles;
        bit rd_pend;
        req_cycles = 0; rv_cycles = 0; rd_pend = 1'b0;
        forever begin
            @(posedge clk); #1;
            mem_gnt = 1'b0;
            mem_rvalid = 1'b0;
            if (!reset) begin
                req_cycles = 0;
                rd_pend = 1'b0;
            end else begin
                if (force_rsp) begin
                    mem_gnt = 1'b1;
                    mem_rvalid = 1'b1;
                    mem_rdata = force_data;
                end
                if (rd_pend) begin
                    if (rv_cycles == rv_dly) begin
                        mem_rvalid = 1'b1;
                        mem_rdata = rsp_data;
                        rd_pend = 1'b0;
                    end else rv_cycles++;
                end
                if (mem_req) begin
                    if (req_cycles == gnt_dly) begin
                        mem_gnt = 1'b1;
                        if (!mem_we) begin
                            rd_pend = 1'b1;
                            rv_cycles = 0;
                        end
                        req_cycles = 0;
                    end else req_cycles++;
                end else req_cycles = 0;
            end
        end
    end

    // Monitor: compares bus beats on gnt and completions on the first unstalled cycle.
    initial begin
        int   stall_cnt;
        bit   req_seen;
        bus_t b;
        cmp_t c;
        stall_cnt = 0; req_seen = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                stall_cnt = 0;
                req_seen = 1'b0;
            end else begin
                if (mem_req && mem_gnt) begin
                    if (bq.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL bus_unexpected actual=gnt expected=none addr=%0h", mem_addr);
                    end else begin
                        b = bq.pop_front();
                        chk("bus_addr", mem_addr, b.addr);
                        chk("bus_we", mem_we, b.we);
                        chk("bus_wstrb", mem_wstrb, b.wstrb);
                        if (b.chk_wd) chk("bus_wdata", mem_wdata, b.wdata);
                    end
                end
                if (MemReadM || MemWriteM) begin
                    if (mem_req) req_seen = 1'b1;
                    if (StallM) stall_cnt++;
                    else begin
                        if (cq.size() == 0) begin
                            checks++; errors++;
                            $display("FAIL done_unexpected actual=done expected=none");
                        end else begin
                            c = cq.pop_front();
                            chk("rdata", ReadDataM, c.rdata);
                            chk("misalign", MisalignM, c.mis);
                            chk("timeout", TimeoutM, c.tmo);
                            chk("stall_cycles", stall_cnt, c.stalls);
                            chk("req_seen", req_seen, c.req);
                            chk("req_low_done", mem_req, 0);
                        end
                        stall_cnt = 0;
                        req_seen = 1'b0;
                    end
                end
            end
        end
    end

    task automatic access(input bit rd, input bit wr, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] wd,
                          input int gd, input int rdl, input logic [31:0] rsp,
                          input logic [3:0] estrb, input logic [31:0] ewd,
                          input logic [31:0] erd, input logic emis, input logic etmo,
                          input int est, input bit ereq);
        cmp_t c;
        bus_t b;
        bit   done;
        c.rdata = erd; c.mis = emis; c.tmo = etmo; c.stalls = est; c.req = ereq;
        cq.push_back(c);
        if (ereq && gd >= 0) begin
            b.addr = {a[31:2], 2'b00}; b.we = wr; b.wstrb = estrb; b.wdata = ewd; b.chk_wd = wr;
            bq.push_back(b);
        end
        gnt_dly = gd; rv_dly = rdl; rsp_data = rsp;
        MemReadM = rd; MemWriteM = wr; Funct3M = f3; ALUResultM = a; WriteDataM = wd;
        done = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (!StallM) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) begin
            checks++; errors++;
            $display("FAIL stall_bound actual=stalled expected=done_within_200");
        end
        @(posedge clk); #1;
        MemReadM = 1'b0; MemWriteM = 1'b0;
    endtask

    initial begin
        bus_t b;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outs", {StallM, ReadDataM, MisalignM, TimeoutM, mem_req, mem_we,
                           mem_addr, mem_wdata, mem_wstrb}, '0);
        reset = 1'b1;
        @(posedge clk); #1;

        //      rd wr f3     addr   wdata         gd rv rsp           strb  ewdata        erd           mis tmo st req
        access(0, 1, 3'b010, 32'h100, 32'hDEADBEEF, 0, 0, 32'h0,        4'hF, 32'hDEADBEEF, 32'h0,        0, 0, 2, 1);
        access(1, 0, 3'b000, 32'h103, 32'h0,        0, 0, 32'h80FF0000, 4'h0, 32'h0,        32'hFFFFFF80, 0, 0, 3, 1);
        access(1, 0, 3'b100, 32'h103, 32'h0,        0, 0, 32'h80FF0000, 4'h0, 32'h0,        32'h00000080, 0, 0, 3, 1);
        access(0, 1, 3'b001, 32'h102, 32'h00001234, 0, 0, 32'h0,        4'hC, 32'h12341234, 32'h00000080, 0, 0, 2, 1);
        access(0, 1, 3'b000, 32'h101, 32'h000000AB, 0, 0, 32'h0,        4'h2, 32'hABABABAB, 32'h00000080, 0, 0, 2, 1);
        access(1, 0, 3'b001, 32'h102, 32'h0,        0, 0, 32'h80017FFF, 4'h0, 32'h0,        32'hFFFF8001, 0, 0, 3, 1);
        access(1, 0, 3'b101, 32'h102, 32'h0,        0, 0, 32'h80017FFF, 4'h0, 32'h0,        32'h00008001, 0, 0, 3, 1);
        access(1, 0, 3'b001, 32'h100, 32'h0,        0, 0, 32'h80017FFF, 4'h0, 32'h0,        32'h00007FFF, 0, 0, 3, 1);
        access(1, 0, 3'b010, 32'h101, 32'h0,        0, 0, 32'h0,        4'h0, 32'h0,        32'h00007FFF, 1, 0, 1, 0);
        access(0, 1, 3'b001, 32'h103, 32'h5555,     0, 0, 32'h0,        4'h0, 32'h0,        32'h00007FFF, 1, 0, 1, 0);
        access(1, 1, 3'b010, 32'h104, 32'h11223344, 3, 0, 32'h0,        4'hF, 32'h11223344, 32'h00007FFF, 0, 0, 5, 1);
        access(1, 0, 3'b010, 32'h108, 32'h0,        1, 2, 32'hA5A50F0F, 4'h0, 32'h0,        32'hA5A50F0F, 0, 0, 6, 1);
        access(0, 1, 3'b000, 32'h103, 32'h000000C3, 0, 0, 32'h0,        4'h8, 32'hC3C3C3C3, 32'hA5A50F0F, 0, 0, 2, 1);
        access(1, 0, 3'b010, 32'h300, 32'h0,       -1, 0, 32'h0,        4'h0, 32'h0,        32'hA5A50F0F, 0, 1, 65, 1);

        // Late responses after the timeout must be ignored.
        force_data = 32'h12345678;
        force_rsp = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        force_rsp = 1'b0;
        @(posedge clk); #1;
        chk("late_rdata", ReadDataM, 32'hA5A50F0F);
        chk("late_req", mem_req, 0);
        chk("late_stall", StallM, 0);

        // Reset asserted while a load sits in WAIT.
        gnt_dly = 0; rv_dly = 20; rsp_data = 32'h0;
        b.addr = 32'h200; b.we = 1'b0; b.wstrb = 4'h0; b.wdata = 32'h0; b.chk_wd = 1'b0;
        bq.push_back(b);
        MemReadM = 1'b1; Funct3M = 3'b010; ALUResultM = 32'h200; WriteDataM = 32'h0;
        repeat (3) begin @(posedge clk); #1; end
        chk("wait_stall", StallM, 1);
        chk("wait_req", mem_req, 0);
        reset = 1'b0;
        #1;
        chk("rst_mid_outs", {StallM, ReadDataM, MisalignM, TimeoutM, mem_req, mem_we,
                             mem_addr, mem_wdata, mem_wstrb}, '0);
        MemReadM = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        access(1, 0, 3'b010, 32'h200, 32'h0,        0, 0, 32'hCAFEF00D, 4'h0, 32'h0,        32'hCAFEF00D, 0, 0, 3, 1);

        repeat (3) @(posedge clk);
        chk("cq_empty", cq.size(), 0);
        chk("bq_empty", bq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
